// File: rtl/front_panel_pkg.sv
// front_panel_pkg: shared types and constants for the front-panel controller.
// Holds the program FSM state encoding, button indices and the debounce counter sizing.
package front_panel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD
  } fp_state_t;

  localparam int STEP_BTN  = 0;
  localparam int WRITE_BTN = 1;

  // A single-cycle debounce still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/front_panel_debouncer.sv
// front_panel_debouncer: one button channel -- 2-flop synchroniser, stability counter,
// debounced level and single-cycle press/release strobes.
module front_panel_debouncer
  import front_panel_pkg::*;
#(
  parameter int CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_stb,
  output logic release_stb
);

  localparam int            CW      = cnt_width(CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic          sync_p0, sync_p1;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (sync_p1 != level) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0     <= 1'b0;
      sync_p1     <= 1'b0;
      cnt         <= '0;
      level       <= 1'b0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      // Synchroniser stage p0 -> p1
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Stability counter stage: any agreement with the level restarts the count
      if (sync_p1 == level || flip) cnt <= '0;
      else                          cnt <= cnt + CW'(1);
      if (flip) level <= ~level;
      press_stb   <= flip & ~level;
      release_stb <= flip & level;
    end
  end

endmodule

// File: rtl/front_panel.sv
// front_panel: debounced buttons, manual step pulse and RAM program-mode write FSM.
// Optional FRONT_PANEL_AUTOINC_EN: auto-incrementing write address while in program mode.
module front_panel
  import front_panel_pkg::*;
#(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_n,
  input  logic                   sw_prog,
  input  logic [ADDR_WIDTH-1:0]  sw_addr,
  input  logic [DATA_WIDTH-1:0]  sw_data,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic                   step_pulse,
  output logic                   prog_we,
  output logic [ADDR_WIDTH-1:0]  prog_addr,
  output logic [DATA_WIDTH-1:0]  prog_data,
  output logic                   prog_busy
);

  logic                  prog_p0, prog_p1;
  logic [ADDR_WIDTH-1:0] addr_p0, addr_p1;
  logic [DATA_WIDTH-1:0] data_p0, data_p1;
  logic [ADDR_WIDTH-1:0] setup_addr;
  fp_state_t             state, state_nxt;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    front_panel_debouncer #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .raw        (~btn_n[i]),
      .level      (btn_level[i]),
      .press_stb  (btn_press[i]),
      .release_stb(btn_release[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_p0 <= 1'b0;
      prog_p1 <= 1'b0;
      addr_p0 <= '0;
      addr_p1 <= '0;
      data_p0 <= '0;
      data_p1 <= '0;
    end else begin
      // Switch synchroniser stage p0 -> p1
      prog_p0 <= sw_prog;
      prog_p1 <= prog_p0;
      addr_p0 <= sw_addr;
      addr_p1 <= addr_p0;
      data_p0 <= sw_data;
      data_p1 <= data_p0;
    end
  end

  assign step_pulse = btn_press[STEP_BTN] & ~prog_p1;

`ifdef FRONT_PANEL_AUTOINC_EN
  logic                  prog_p2;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  // Counter tracks the switches in run mode and on entry to program mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_p2  <= 1'b0;
      addr_cnt <= '0;
    end else begin
      prog_p2 <= prog_p1;
      if (!prog_p1 || !prog_p2) addr_cnt <= addr_p1;
      else if (state == WRITE)  addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
    end
  end

  assign setup_addr = addr_cnt;
`else
  assign setup_addr = addr_p1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prog_addr <= '0;
      prog_data <= '0;
    end else begin
      state <= state_nxt;
      // Address/data only move when a write is actually committed.
      if (state == SETUP && state_nxt == WRITE) begin
        prog_addr <= setup_addr;
        prog_data <= data_p1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    prog_we   = 1'b0;
    prog_busy = (state != IDLE);
    unique case (state)
      IDLE:  if (prog_p1 && btn_press[WRITE_BTN]) state_nxt = SETUP;
      SETUP: state_nxt = prog_p1 ? WRITE : IDLE;
      WRITE: begin
        prog_we   = 1'b1;
        state_nxt = prog_p1 ? HOLD : IDLE;
      end
      HOLD:  if (!prog_p1 || !btn_level[WRITE_BTN]) state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_front_panel.sv
// tb_front_panel: scoreboard bench for front_panel with DEBOUNCE_CYCLES = 4.
// Stimulus queues expected strobes/writes; a negedge monitor matches them against the DUT.
module tb_front_panel;

  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 2 + DEB;

  localparam int K_P0   = 0;
  localparam int K_R0   = 1;
  localparam int K_P1   = 2;
  localparam int K_R1   = 3;
  localparam int K_STEP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_n;
  logic          sw_prog;
  logic [AW-1:0] sw_addr;
  logic [DW-1:0] sw_data;
  logic [NB-1:0] btn_level, btn_press, btn_release;
  logic          step_pulse, prog_we, prog_busy;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {int kind; int at;} ev_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  ev_t   ev_q[$];
  wr_t   wr_q[$];
  string ev_names[7] = '{"press0", "release0", "press1", "release1", "step", "press2", "release2"};

  front_panel #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DEB),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .sw_prog    (sw_prog),
    .sw_addr    (sw_addr),
    .sw_data    (sw_data),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .step_pulse (step_pulse),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_busy  (prog_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({btn_level, btn_press, btn_release, step_pulse, prog_we, prog_busy, prog_addr, prog_data});
  endfunction

  task automatic press(input int ch, input bit exp_step);
    btn_n[ch] = 1'b0;
    ev_q.push_back('{ch * 2, cyc + LAT});
    if (exp_step) ev_q.push_back('{K_STEP, cyc + LAT});
  endtask

  task automatic unpress(input int ch);
    btn_n[ch] = 1'b1;
    ev_q.push_back('{ch * 2 + 1, cyc + LAT});
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_q.push_back('{a, d});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: match every DUT strobe and write against the scoreboard queues
  always @(negedge clk) begin : mon
    logic [6:0] ev;
    int         idx;
    wr_t        w;
    if (!rst) begin
      ev = {btn_release[2], btn_press[2], step_pulse, btn_release[1], btn_press[1],
            btn_release[0], btn_press[0]};
      for (int k = 0; k < 7; k++) begin
        if (ev[k]) begin
          idx = -1;
          for (int j = 0; j < ev_q.size(); j++)
            if (idx < 0 && ev_q[j].kind == k) idx = j;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected: got strobe at cycle %0d, expected none", ev_names[k], cyc);
          end else begin
            chk({ev_names[k], "_cycle"}, cyc, ev_q[idx].at);
            ev_q.delete(idx);
          end
        end
      end
      for (int j = ev_q.size() - 1; j >= 0; j--) begin
        if (ev_q[j].at < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missing: got no strobe, expected at cycle %0d", ev_names[ev_q[j].kind], ev_q[j].at);
          ev_q.delete(j);
        end
      end
      if (prog_we) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL prog_we unexpected: got write addr=%0h data=%0h, expected none", prog_addr, prog_data);
        end else begin
          w = wr_q.pop_front();
          chk("write_addr", int'(prog_addr), int'(w.addr));
          chk("write_data", int'(prog_data), int'(w.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] exp_a;
    rst     = 1'b1;
    btn_n   = '1;
    sw_prog = 1'b0;
    sw_addr = '0;
    sw_data = '0;
    cycles(3);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    cycles(2);

    // 1: bounce on STEP, then a clean press in run mode
    for (int i = 0; i < 10; i++) begin
      btn_n[0] = ~btn_n[0];
      cycles(2);
    end
    chk("level0_during_bounce", int'(btn_level[0]), 0);
    press(0, 1'b1);
    cycles(LAT + 2);
    chk("level0_after_bounce", int'(btn_level[0]), 1);
    unpress(0);
    cycles(LAT + 4);
    chk("level0_released", int'(btn_level[0]), 0);

    // 2: step in run mode, suppressed in program mode
    press(0, 1'b1);
    cycles(10);
    unpress(0);
    cycles(10);
    sw_prog = 1'b1;
    cycles(4);
    press(0, 1'b0);
    cycles(10);
    unpress(0);
    cycles(10);

    // 3: single write while WRITE is held 100 cycles
    sw_prog = 1'b0;
    sw_addr = 4'hA;
    sw_data = 8'h3C;
    cycles(4);
    sw_prog = 1'b1;
    cycles(4);
    press(1, 1'b0);
    expect_write(4'hA, 8'h3C);
    cycles(100);
    chk("busy_while_held", int'(prog_busy), 1);
    chk("level1_held", int'(btn_level[1]), 1);
    chk("addr_held", int'(prog_addr), 'hA);
    unpress(1);
    cycles(LAT);
    chk("busy_at_release_strobe", int'(prog_busy), 1);
    cycles(1);
    chk("busy_after_release", int'(prog_busy), 0);
    cycles(4);

    // 4: sw_prog drops so the FSM sees run mode while in SETUP
    press(1, 1'b0);
    cycles(5);
    sw_prog = 1'b0;
    cycles(2);
    chk("busy_in_setup", int'(prog_busy), 1);
    cycles(1);
    chk("busy_abort", int'(prog_busy), 0);
    unpress(1);
    cycles(LAT + 4);

    // 5: three writes starting from address F
    sw_addr = 4'hF;
    cycles(4);
    sw_prog = 1'b1;
    cycles(4);
    for (int i = 0; i < 3; i++) begin
      sw_data = DW'(8'h11 * (i + 1));
      cycles(4);
`ifdef FRONT_PANEL_AUTOINC_EN
      exp_a = AW'(15 + i);
`else
      exp_a = 4'hF;
`endif
      press(1, 1'b0);
      expect_write(exp_a, DW'(8'h11 * (i + 1)));
      cycles(10);
      unpress(1);
      cycles(10);
    end
    chk("idle_after_writes", int'(prog_busy), 0);

    // 6: reset while STEP is held debounced
    sw_prog = 1'b0;
    cycles(4);
    press(0, 1'b1);
    cycles(10);
    chk("level0_before_reset", int'(btn_level[0]), 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("outputs_after_reset", outs(), 0);
    ev_q.push_back('{K_P0, cyc + LAT});
    ev_q.push_back('{K_STEP, cyc + LAT});
    cycles(LAT + 2);
    chk("level0_after_reset", int'(btn_level[0]), 1);
    unpress(0);
    cycles(LAT + 4);

    chk("events_outstanding", ev_q.size(), 0);
    chk("writes_outstanding", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
